// File: rtl/fp_align_add.sv
// fp_align_add: two-stage align-and-add front end for a single-precision adder.
// Stage 1 unpacks both operands, applies the subtract flip and orders them by
// magnitude. Stage 2 right-aligns the smaller significand (folding shifted-out
// bits into a sticky LSB) and adds or subtracts, producing {S, CO, ES, MS}
// for the normalise/round stage. Valid/ready handshakes on both sides.
module fp_align_add #(
  parameter int EW = 8,
  parameter int FW = 23,
  parameter int XW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [EW+FW:0]      A,
  input  logic [EW+FW:0]      B,
  input  logic                SUB,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                S,
  output logic                CO,
  output logic [EW-1:0]       ES,
  output logic [FW+XW:0]      MS,
  output logic                EXC
);

  localparam int            W    = 1 + EW + FW;
  localparam int            MW   = FW + 1 + XW;
  localparam logic [EW-1:0] MW_E = EW'(MW);

  // ---------------- handshake ----------------
  logic w_s2_load;
  logic w_in_fire;
  logic r1_valid;
  logic r_out_valid;

  assign w_s2_load = !r_out_valid || OUT_READY;
  assign IN_READY  = !r1_valid || w_s2_load;
  assign w_in_fire = IN_VALID && IN_READY;
  assign OUT_VALID = r_out_valid;

  // ---------------- stage 1: unpack and order ----------------
  logic [EW-1:0] w_ea, w_eb, w_eaf, w_ebf;
  logic [FW-1:0] w_fa, w_fb;
  logic          w_sa, w_sb, w_a_big;

  assign w_ea    = A[W-2:FW];
  assign w_eb    = B[W-2:FW];
  assign w_fa    = A[FW-1:0];
  assign w_fb    = B[FW-1:0];
  assign w_sa    = A[W-1];
  assign w_sb    = B[W-1] ^ SUB;
  // Denormals share the exponent of the smallest normal.
  assign w_eaf   = (w_ea == '0) ? EW'(1) : w_ea;
  assign w_ebf   = (w_eb == '0) ? EW'(1) : w_eb;
  // Ties pick A so an exact cancellation always subtracts B from A.
  assign w_a_big = {w_eaf, w_fa} >= {w_ebf, w_fb};

  logic          r1_sl, r1_op, r1_exc;
  logic [EW-1:0] r1_el, r1_d;
  logic [FW:0]   r1_ml, r1_msm;

  // Stage-1 valid: refills whenever the stage can accept.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r1_valid <= 1'b0;
    else if (IN_READY) r1_valid <= IN_VALID;
  end

  // Stage-1 payload: captured on each accepted input.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the valid bit alone decides
    // whether their contents are meaningful.
    if (w_in_fire) begin
      r1_exc <= (&w_ea) || (&w_eb);
      r1_op  <= w_sa ^ w_sb;
      if (w_a_big) begin
        r1_sl  <= w_sa;
        r1_el  <= w_eaf;
        r1_d   <= w_eaf - w_ebf;
        r1_ml  <= {(w_ea != '0), w_fa};
        r1_msm <= {(w_eb != '0), w_fb};
      end else begin
        r1_sl  <= w_sb;
        r1_el  <= w_ebf;
        r1_d   <= w_ebf - w_eaf;
        r1_ml  <= {(w_eb != '0), w_fb};
        r1_msm <= {(w_ea != '0), w_fa};
      end
    end
  end

  // ---------------- stage 2: align and add ----------------
  logic [MW-1:0] w_l_ext, w_s_ext, w_mask, w_shr, w_s_al, w_diff;
  logic [MW:0]   w_sum;

  assign w_l_ext = {r1_ml, XW'(0)};
  assign w_s_ext = {r1_msm, XW'(0)};
  assign w_mask  = ~({MW{1'b1}} << r1_d);
  assign w_shr   = w_s_ext >> r1_d;
  // Bits shifted below bit 0 collapse into the sticky LSB.
  assign w_s_al  = (r1_d >= MW_E) ? {{(MW-1){1'b0}}, |w_s_ext}
                                  : (w_shr | {{(MW-1){1'b0}}, |(w_s_ext & w_mask)});
  assign w_sum   = {1'b0, w_l_ext} + {1'b0, w_s_al};
  assign w_diff  = w_l_ext - w_s_al;

  logic          w_s, w_co;
  logic [EW-1:0] w_es;
  logic [MW-1:0] w_ms;

  // Result select: add with carry renormalise, or subtract; exceptions zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_s  = r1_sl;
    w_co = 1'b0;
    w_es = r1_el;
    w_ms = w_diff;
    if (!r1_op) begin
      if (w_sum[MW]) begin
        w_co = 1'b1;
        w_ms = w_sum[MW:1] | {{(MW-1){1'b0}}, w_sum[0]};
      end else begin
        w_ms = w_sum[MW-1:0];
      end
    end else if (w_diff == '0) begin
      w_s = 1'b0;
    end
    if (r1_exc) begin
      w_s  = 1'b0;
      w_co = 1'b0;
      w_es = '0;
      w_ms = '0;
    end
  end

  logic r_exc;

  // Output stage: loads when empty or drained; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      S           <= 1'b0;
      CO          <= 1'b0;
      ES          <= '0;
      MS          <= '0;
      r_exc       <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r1_valid;
      if (r1_valid) begin
        S     <= w_s;
        CO    <= w_co;
        ES    <= w_es;
        MS    <= w_ms;
        r_exc <= r1_exc;
      end
    end
  end

  assign EXC = r_exc;

endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: directed cases plus randomized traffic with random
// backpressure, checked against an arithmetic reference model and a queue.
module tb_fp_align_add;

  typedef struct packed {
    logic        s;
    logic        co;
    logic [7:0]  es;
    logic [27:0] ms;
    logic        exc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_VALID, IN_READY, SUB, OUT_VALID, OUT_READY;
  logic        S, CO, EXC;
  logic [31:0] A, B;
  logic [7:0]  ES;
  logic [27:0] MS;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_align_add dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .SUB(SUB),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .S(S), .CO(CO), .ES(ES), .MS(MS), .EXC(EXC)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unpacked values.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    res_t   r;
    longint ea, eb, ma, mb, ka, kb, el, esm, ml, msm, d, lx, sx, t, sum, m;
    logic   sa, sb, sl, ss;
    r  = '0;
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      r.exc = 1'b1;
      return r;
    end
    sa = a[31];
    sb = b[31] ^ sub;
    ma = ((ea != 0) ? 64'h800000 : 64'h0) + longint'(a[22:0]);
    mb = ((eb != 0) ? 64'h800000 : 64'h0) + longint'(b[22:0]);
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    ka = ea * 64'h800000 + longint'(a[22:0]);
    kb = eb * 64'h800000 + longint'(b[22:0]);
    if (ka >= kb) begin
      sl = sa; ss = sb; el = ea; esm = eb; ml = ma; msm = mb;
    end else begin
      sl = sb; ss = sa; el = eb; esm = ea; ml = mb; msm = ma;
    end
    d  = el - esm;
    lx = ml * 16;
    sx = msm * 16;
    if (d >= 28) sx = (sx != 0) ? 1 : 0;
    else begin
      t = sx >> d;
      if ((t << d) != sx) t = t | 1;
      sx = t;
    end
    if (sl == ss) begin
      sum = lx + sx;
      if (sum >= (longint'(1) << 28)) begin
        r.co = 1'b1;
        m = (sum >> 1) | (sum & 1);
      end else m = sum;
    end else begin
      m = (lx - sx) & 64'hFFFFFFF;
    end
    r.ms = 28'(m);
    r.s  = (sl != ss && m == 0) ? 1'b0 : sl;
    r.es = 8'(el);
    return r;
  endfunction

  // Monitor: scoreboard on both handshakes plus stall stability.
  logic prev_stall = 1'b0;
  res_t prev_out;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", OUT_VALID, 1'b1);
        check("stall_hold", {S, CO, ES, MS, EXC}, prev_out);
      end
      if (OUT_VALID && OUT_READY) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", OUT_VALID, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("out_s", S, e.s);
          check("out_co", CO, e.co);
          check("out_es", ES, e.es);
          check("out_ms", MS, e.ms);
          check("out_exc", EXC, e.exc);
        end
      end
      if (IN_VALID && IN_READY) exp_q.push_back(model(A, B, SUB));
      prev_stall = OUT_VALID && !OUT_READY;
      prev_out   = {S, CO, ES, MS, EXC};
    end
  end

  // One operation with a fully drained pipe: checks 2-cycle latency and fields.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input res_t e);
    A = a; B = b; SUB = sub; IN_VALID = 1'b1;
    check({tag, "_in_ready"}, IN_READY, 1'b1);
    @(posedge clk); #1;
    IN_VALID = 1'b0;
    check({tag, "_lat1_valid"}, OUT_VALID, 1'b0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, OUT_VALID, 1'b1);
    check({tag, "_fields"}, {S, CO, ES, MS, EXC}, e);
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] near);
    int   e;
    logic [7:0] ex;
    if ($urandom_range(0, 1) == 0) e = int'(near) + int'($urandom_range(0, 8)) - 4;
    else e = int'($urandom_range(0, 254));
    if (e < 0) e = 0;
    if (e > 254) e = 254;
    ex = 8'(e);
    if ($urandom_range(0, 19) == 0) ex = 8'hFF;
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  logic [31:0] ops_a[4];
  logic [31:0] ops_b[4];
  int          acc, base_out, cyc;
  logic        hs;

  initial begin
    rst = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; SUB = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_fields", {S, CO, ES, MS, EXC}, 38'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", IN_READY, 1'b1);

    directed("t1_add_one",  32'h3F800000, 32'h3F800000, 1'b0, '{1'b0, 1'b1, 8'h7F, 28'h8000000, 1'b0});
    directed("t2_cancel",   32'h3F800000, 32'h3F800000, 1'b1, '{1'b0, 1'b0, 8'h7F, 28'h0000000, 1'b0});
    directed("t3_carry",    32'h3FC00000, 32'h3F400000, 1'b0, '{1'b0, 1'b1, 8'h7F, 28'h9000000, 1'b0});
    directed("t4_sticky",   32'h3F800000, 32'h30800000, 1'b0, '{1'b0, 1'b0, 8'h7F, 28'h8000001, 1'b0});
    directed("t6_inf",      32'h7F800000, 32'h40490FDB, 1'b0, '{1'b0, 1'b0, 8'h00, 28'h0000000, 1'b1});
    directed("t_neg_big",   32'hC0000000, 32'h3F800000, 1'b0, '{1'b1, 1'b0, 8'h80, 28'h4000000, 1'b0});
    @(posedge clk); #1;

    // Stall: four ops offered while downstream refuses; only two may enter.
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = rand_op(8'h80);
      ops_b[i] = rand_op(8'h80);
    end
    base_out = n_out;
    OUT_READY = 1'b0;
    acc = 0;
    IN_VALID = 1'b1; SUB = 1'b0;
    for (int c = 0; c < 5; c++) begin
      A = ops_a[acc]; B = ops_b[acc];
      @(negedge clk) hs = IN_VALID && IN_READY;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    check("stall_accepted", acc, 2);
    check("stall_in_ready", IN_READY, 1'b0);
    OUT_READY = 1'b1;
    cyc = 0;
    while (acc < 4 && cyc < 20) begin
      A = ops_a[acc]; B = ops_b[acc];
      @(negedge clk) hs = IN_VALID && IN_READY;
      @(posedge clk); #1;
      if (hs) acc++;
      cyc++;
    end
    IN_VALID = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("stall_all_out", n_out - base_out, 4);
    check("stall_q_empty", exp_q.size(), 0);

    // Reset with two operations in flight: neither may ever appear.
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      A = rand_op(8'h40); B = rand_op(8'h40);
      @(posedge clk); #1;
    end
    IN_VALID = 1'b0;
    base_out = n_out;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_out_valid", OUT_VALID, 1'b0);
    OUT_READY = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rstmid_none_emitted", n_out - base_out, 0);

    // Random traffic with random backpressure.
    base_out = n_out;
    acc = 0;
    hs = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!IN_VALID || hs) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        A = rand_op(8'($urandom_range(0, 254)));
        B = ($urandom_range(0, 9) == 0) ? A : rand_op(A[30:23]);
        SUB = 1'($urandom_range(0, 1));
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      @(negedge clk) hs = IN_VALID && IN_READY;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_q_empty", exp_q.size(), 0);
    check("random_count", n_out - base_out, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
